oled_text_feeder: RTL

Character buffer and sequencer that sits directly upstream of `oled_control`. It accepts ASCII bytes from any producer through a write-strobe FIFO and drains them to `oled_control` using its four-phase `send_data`/`send_data_valid`/`send_done` handshake. It tracks the text cursor on a COLS×ROWS character screen, and can optionally expand newline into space padding. It replaces hard-coded string sequencing in the top level.

---
 rtl/oled_text_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/oled_text_feeder.sv
// Text FIFO feeding oled_control over the send_data/valid/done handshake, with cursor tracking.
// Optional newline-to-space padding is enabled by defining OLED_TEXT_FEEDER_NEWLINE_EN.
module oled_text_feeder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROWS  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [7:0]              send_data,
    output logic                    send_data_valid,
    input  logic                    send_done,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d, empty_q, empty_d, overflow_q;
    logic [7:0]    head;
    logic          pad_pending, start, pop, push;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [7:0]    data_q;
    logic          valid_q;

`ifdef OLED_TEXT_FEEDER_NEWLINE_EN
    localparam int unsigned PADW = $clog2(COLS + 1);
    logic [PADW-1:0] pad_q;
    assign pad_pending = (pad_q != '0);
`else
    assign pad_pending = 1'b0;
`endif

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        start    = (state_q == StIdle) && !send_done && (!empty_q || pad_pending);
        pop      = start && !pad_pending;
        // A pop in the same cycle frees a slot, so a write while full still lands.
        push     = wr_en && (!full_q || pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= wr_en && !push;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
`ifdef OLED_TEXT_FEEDER_NEWLINE_EN
            pad_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        valid_q <= 1'b1;
                        state_q <= StSend;
                        data_q  <= head;
`ifdef OLED_TEXT_FEEDER_NEWLINE_EN
                        if (pad_pending) begin
                            data_q <= 8'h20;
                            pad_q  <= pad_q - PADW'(1);
                        end else if (head == 8'h0A) begin
                            // First pad slot goes out now; the counter covers the rest of the line.
                            data_q <= 8'h20;
                            pad_q  <= PADW'(COLS - 1) - PADW'(col_q);
                        end
`endif
                    end
                end
                StSend: begin
                    if (send_done) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        if (col_q == CW'(COLS - 1)) begin
                            col_q <= '0;
                            row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign full            = full_q;
    assign empty           = empty_q;
    assign overflow        = overflow_q;
    assign send_data       = data_q;
    assign send_data_valid = valid_q;
    assign cursor_col      = col_q;
    assign cursor_row      = row_q;

endmodule
